bus_initiator: RTL and testbench

BUS_INITIATOR -- requirements
Module: bus_initiator

---
 rtl/bus_initiator.sv | 167 ++++++++++++++++
 tb/tb_bus_initiator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_initiator.sv
// bus_initiator: single-outstanding master on a shared 8-bit tri-state bus.
// A client hands over one read or write at a time. Writes drive the bus for one cycle.
// Reads hold the address for READ_LATENCY cycles and then sample BUS_DATA.
// Every bus read is followed by a TURN cycle, so a responder can release the bus
// before this block drives it again.
// Optional feature macro: BUS_INITIATOR_READBACK_EN. When it is defined, each write
// is read back and compared, and any mismatch sets the sticky RB_ERR flag.
module bus_initiator #(
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [7:0]  PARK_ADDR    = 8'hFF
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  output logic [7:0] BUS_ADDR,
  output logic       BUS_WE,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_WE,
  input  logic [7:0] REQ_ADDR,
  input  logic [7:0] REQ_WDATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_RDATA,
  output logic       RB_ERR
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_WAIT = 3'd2,
    RB_WAIT = 3'd3,
    TURN    = 3'd4
  } state_t;

  // The counter runs from READ_LATENCY-1 down to 0, so the wait states last READ_LATENCY cycles.
  localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rsp_valid_q, rsp_valid_d;
`ifdef BUS_INITIATOR_READBACK_EN
  logic       rb_err_q, rb_err_d;
`endif

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath and response registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q       <= 3'd0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
`ifdef BUS_INITIATOR_READBACK_EN
      rb_err_q    <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef BUS_INITIATOR_READBACK_EN
      rb_err_q    <= rb_err_d;
`endif
    end
  end

  // Next-state logic: every bus read (RD_WAIT or RB_WAIT) leaves through TURN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (REQ_VALID) state_d = REQ_WE ? WRITE : RD_WAIT;
      end
      WRITE: begin
`ifdef BUS_INITIATOR_READBACK_EN
        state_d = RB_WAIT;
`else
        state_d = IDLE;
`endif
      end
      RD_WAIT: begin
        if (cnt_q == 3'd0) state_d = TURN;
      end
`ifdef BUS_INITIATOR_READBACK_EN
      RB_WAIT: begin
        if (cnt_q == 3'd0) state_d = TURN;
      end
`endif
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: capture the request, count the wait cycles, and sample the bus.
  always_comb begin
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
`ifdef BUS_INITIATOR_READBACK_EN
    rb_err_d    = rb_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          addr_d  = REQ_ADDR;
          wdata_d = REQ_WDATA;
          cnt_d   = REQ_WE ? 3'd0 : CNT_LOAD;
        end
      end
`ifdef BUS_INITIATOR_READBACK_EN
      WRITE: cnt_d = CNT_LOAD;
`endif
      RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d     = BUS_DATA;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
`ifdef BUS_INITIATOR_READBACK_EN
      RB_WAIT: begin
        if (cnt_q == 3'd0) begin
          // Case inequality: an undriven (Z/X) bus must count as a mismatch.
          if (BUS_DATA !== wdata_q) rb_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Output decode: the bus parks in IDLE and TURN, and only WRITE enables the data driver.
  always_comb begin
    REQ_READY = (state_q == IDLE);
    BUS_WE    = (state_q == WRITE);
    BUS_ADDR  = PARK_ADDR;
    case (state_q)
      WRITE, RD_WAIT, RB_WAIT: BUS_ADDR = addr_q;
      default:                 BUS_ADDR = PARK_ADDR;
    endcase
  end

  assign BUS_DATA  = BUS_WE ? wdata_q : 8'bzzzz_zzzz;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rdata_q;
`ifdef BUS_INITIATOR_READBACK_EN
  assign RB_ERR    = rb_err_q;
`else
  assign RB_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator (READ_LATENCY=2, PARK_ADDR=8'hFF).
// The responder is a 128-byte RAM at base 0. After reset its contents are addr ^ 8'h5C.
// Once the address has moved away, it keeps driving the bus for one more cycle.
module tb_bus_initiator;

  localparam int RL = 2;
`ifdef BUS_INITIATOR_READBACK_EN
  localparam logic [7:0] EXP_WR_C2_ADDR = 8'h10;
  localparam int         EXP_WR_READY   = RL + 3;
`else
  localparam logic [7:0] EXP_WR_C2_ADDR = 8'hFF;
  localparam int         EXP_WR_READY   = 2;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  wire  [7:0] BUS_DATA;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic       REQ_WE = 1'b0;
  logic [7:0] REQ_ADDR = 8'h00;
  logic [7:0] REQ_WDATA = 8'h00;
  logic       RSP_VALID;
  logic [7:0] RSP_RDATA;
  logic       RB_ERR;

  int checks = 0;
  int failures = 0;

  bus_initiator #(.READ_LATENCY(RL), .PARK_ADDR(8'hFF)) dut (
    .CLK(CLK), .RESET(RESET), .BUS_DATA(BUS_DATA), .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RB_ERR(RB_ERR)
  );

  always #5 CLK = ~CLK;

  // RAM responder
  logic [7:0] mem [0:127];
  logic       rsp_en_q = 1'b0;
  logic [7:0] rsp_addr_q = 8'h00;
  wire        in_win    = !BUS_WE && !BUS_ADDR[7];
  wire        rsp_drive = in_win || rsp_en_q;
  wire  [7:0] rsp_data  = in_win ? mem[BUS_ADDR[6:0]] : mem[rsp_addr_q[6:0]];
  wire        clash     = BUS_WE && rsp_drive;
  assign BUS_DATA = rsp_drive ? rsp_data : 8'bzzzz_zzzz;

  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i) ^ 8'h5C;
    end else if (BUS_WE && !BUS_ADDR[7]) begin
      mem[BUS_ADDR[6:0]] <= BUS_DATA;
    end
    rsp_en_q <= in_win;
    if (in_win) rsp_addr_q <= BUS_ADDR;
  end

  // Present a request in the current cycle; it is accepted at the next edge, and the task returns in cycle 1.
  task automatic send(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_WDATA = wdata;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  // Starting at cycle 1, step cycles until REQ_READY is seen; n is the cycle index, or 40 if the bound expires.
  task automatic wait_ready(output int n);
    n = 1;
    while (!REQ_READY && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", REQ_READY); end
    checks++; if (BUS_ADDR !== 8'hFF) begin failures++; $display("FAIL reset_addr got=%h want=ff", BUS_ADDR); end
    checks++; if (BUS_WE !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", BUS_WE); end
    checks++; if (RSP_VALID !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", RSP_VALID); end
    checks++; if (RSP_RDATA !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h want=00", RSP_RDATA); end
    checks++; if (RB_ERR !== 1'b0) begin failures++; $display("FAIL reset_rb_err got=%b want=0", RB_ERR); end
  endtask

  task automatic test_write_read;
    int n;
    send(1'b1, 8'h10, 8'h5A);
    checks++; if (BUS_WE !== 1'b1) begin failures++; $display("FAIL wr_c1_we got=%b want=1", BUS_WE); end
    checks++; if (BUS_ADDR !== 8'h10) begin failures++; $display("FAIL wr_c1_addr got=%h want=10", BUS_ADDR); end
    checks++; if (BUS_DATA !== 8'h5A) begin failures++; $display("FAIL wr_c1_data got=%h want=5a", BUS_DATA); end
    checks++; if (REQ_READY !== 1'b0) begin failures++; $display("FAIL wr_c1_ready got=%b want=0", REQ_READY); end
    @(posedge CLK); #1;
    checks++; if (BUS_WE !== 1'b0) begin failures++; $display("FAIL wr_c2_we got=%b want=0", BUS_WE); end
    checks++; if (BUS_ADDR !== EXP_WR_C2_ADDR) begin failures++; $display("FAIL wr_c2_addr got=%h want=%h", BUS_ADDR, EXP_WR_C2_ADDR); end
    checks++; if (RSP_VALID !== 1'b0) begin failures++; $display("FAIL wr_no_rsp got=%b want=0", RSP_VALID); end
    checks++; if (mem[16] !== 8'h5A) begin failures++; $display("FAIL wr_ram got=%h want=5a", mem[16]); end
    n = 2;
    while (!REQ_READY && n < 40) begin @(posedge CLK); #1; n++; end
    checks++; if (n !== EXP_WR_READY) begin failures++; $display("FAIL wr_spacing got=%0d want=%0d", n, EXP_WR_READY); end
    send(1'b0, 8'h10, 8'h00);
    checks++; if (BUS_ADDR !== 8'h10 || BUS_WE !== 1'b0) begin failures++; $display("FAIL rd_c1_bus got=%h/%b want=10/0", BUS_ADDR, BUS_WE); end
    @(posedge CLK); #1;
    checks++; if (RSP_VALID !== 1'b0 || BUS_ADDR !== 8'h10) begin failures++; $display("FAIL rd_c2 got=%b/%h want=0/10", RSP_VALID, BUS_ADDR); end
    @(posedge CLK); #1;
    checks++; if (RSP_VALID !== 1'b1) begin failures++; $display("FAIL rd_c3_valid got=%b want=1", RSP_VALID); end
    checks++; if (RSP_RDATA !== 8'h5A) begin failures++; $display("FAIL rd_c3_rdata got=%h want=5a", RSP_RDATA); end
    checks++; if (BUS_ADDR !== 8'hFF || REQ_READY !== 1'b0) begin failures++; $display("FAIL rd_c3_turn got=%h/%b want=ff/0", BUS_ADDR, REQ_READY); end
    @(posedge CLK); #1;
    checks++; if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) begin failures++; $display("FAIL rd_c4 got=%b/%b want=0/1", RSP_VALID, REQ_READY); end
    checks++; if (RSP_RDATA !== 8'h5A) begin failures++; $display("FAIL rd_hold got=%h want=5a", RSP_RDATA); end
  endtask

  task automatic test_back_to_back;
    int acc = -1;
    int rsp = -1;
    int wcyc = -1;
    int bad = 0;
    logic [7:0] taddr = 8'h00;
    logic [7:0] wd = 8'h00;
    send(1'b0, 8'h20, 8'h00);
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 8'h21; REQ_WDATA = 8'hC3;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) begin @(posedge CLK); #1; end
      if (acc >= 0 && k == acc + 1) REQ_VALID = 1'b0;
      if (clash) bad++;
      if (RSP_VALID && rsp < 0) begin rsp = k; taddr = BUS_ADDR; end
      if (BUS_WE && wcyc < 0) begin wcyc = k; wd = BUS_DATA; end
      if (REQ_READY && acc < 0) acc = k;
    end
    REQ_VALID = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_contention got=%0d want=0", bad); end
    checks++; if (rsp !== 3) begin failures++; $display("FAIL b2b_rsp_cycle got=%0d want=3", rsp); end
    checks++; if (taddr !== 8'hFF) begin failures++; $display("FAIL b2b_turn_addr got=%h want=ff", taddr); end
    checks++; if (RSP_RDATA !== 8'h7C) begin failures++; $display("FAIL b2b_rdata got=%h want=7c", RSP_RDATA); end
    checks++; if (acc !== 4) begin failures++; $display("FAIL b2b_accept_cycle got=%0d want=4", acc); end
    checks++; if (wcyc !== 5 || wd !== 8'hC3) begin failures++; $display("FAIL b2b_write got=%0d/%h want=5/c3", wcyc, wd); end
    checks++; if (RB_ERR !== 1'b0) begin failures++; $display("FAIL b2b_rb_err got=%b want=0", RB_ERR); end
  endtask

  task automatic test_unmapped_read;
    int rsp = -1;
    int pulses = 0;
    int rdy = -1;
    send(1'b0, 8'h90, 8'h00);
    checks++; if (BUS_ADDR !== 8'h90) begin failures++; $display("FAIL unm_addr got=%h want=90", BUS_ADDR); end
    for (int k = 2; k <= 8; k++) begin
      @(posedge CLK); #1;
      if (RSP_VALID) begin pulses++; if (rsp < 0) rsp = k; end
      if (REQ_READY && rdy < 0) rdy = k;
    end
    checks++; if (rsp !== 3 || pulses !== 1) begin failures++; $display("FAIL unm_rsp got=%0d/%0d want=3/1", rsp, pulses); end
    checks++; if (rdy !== 4) begin failures++; $display("FAIL unm_idle got=%0d want=4", rdy); end
  endtask

  task automatic test_reset_mid_read;
    int pulses = 0;
    send(1'b0, 8'h10, 8'h00);
    checks++; if (BUS_ADDR !== 8'h10) begin failures++; $display("FAIL rst_pre_addr got=%h want=10", BUS_ADDR); end
    RESET = 1'b1;
    #1;
    checks++; if (BUS_ADDR !== 8'hFF || BUS_WE !== 1'b0) begin failures++; $display("FAIL rst_park got=%h/%b want=ff/0", BUS_ADDR, BUS_WE); end
    checks++; if (REQ_READY !== 1'b1 || RSP_RDATA !== 8'h00) begin failures++; $display("FAIL rst_force got=%b/%h want=1/00", REQ_READY, RSP_RDATA); end
    @(posedge CLK); @(posedge CLK); #1;
    RESET = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (RSP_VALID) pulses++;
      @(posedge CLK); #1;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL rst_no_rsp got=%0d want=0", pulses); end
    checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", REQ_READY); end
  endtask

`ifdef BUS_INITIATOR_READBACK_EN
  task automatic test_readback;
    int n;
    send(1'b1, 8'h90, 8'hA5);
    wait_ready(n);
    checks++; if (n !== RL + 3) begin failures++; $display("FAIL rb_spacing got=%0d want=%0d", n, RL + 3); end
    checks++; if (RB_ERR !== 1'b1) begin failures++; $display("FAIL rb_unmapped got=%b want=1", RB_ERR); end
    send(1'b1, 8'h05, 8'h11);
    wait_ready(n);
    checks++; if (RB_ERR !== 1'b1) begin failures++; $display("FAIL rb_sticky got=%b want=1", RB_ERR); end
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    send(1'b1, 8'h05, 8'h11);
    wait_ready(n);
    checks++; if (RB_ERR !== 1'b0) begin failures++; $display("FAIL rb_match got=%b want=0", RB_ERR); end
  endtask
`else
  task automatic test_rb_tied;
    int n;
    send(1'b1, 8'h90, 8'hA5);
    wait_ready(n);
    checks++; if (n !== 2) begin failures++; $display("FAIL wr_unm_spacing got=%0d want=2", n); end
    checks++; if (RB_ERR !== 1'b0) begin failures++; $display("FAIL rb_tied got=%b want=0", RB_ERR); end
  endtask
`endif

  initial begin
    test_reset;
    test_write_read;
    test_back_to_back;
    test_unmapped_read;
    test_reset_mid_read;
`ifdef BUS_INITIATOR_READBACK_EN
    test_readback;
`else
    test_rb_tied;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
